// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the uart_tx arbiter.
//   arb_state_e - arbiter FSM encoding (IDLE, WAIT_BUSY, WAIT_DONE, CR, LF)
//   tail_e      - which byte of a grant is in flight when CR/LF tails are enabled
//   ASCII_CR/LF - bytes appended after an end-of-line grant
//   idx_width() - bit width needed to index n items (minimum 1)
package uart_arb_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitBusy = 3'd1,
    StWaitDone = 3'd2,
    StCr       = 3'd3,
    StLf       = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    PhData = 2'd0,
    PhCr   = 2'd1,
    PhLf   = 2'd2
  } tail_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational cyclic priority search.
// The first asserted request at or after i_ptr (wrapping upward) wins.
//   i_req     - request vector
//   i_ptr     - search start index (must be < NUM_REQ)
//   o_gnt     - one-hot grant, zero when no request
//   o_gnt_idx - index of the granted request
//   o_any     - at least one request is asserted
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_rot;
  logic               w_found;
  int unsigned        w_sum;

  // Rotate so the pointer position lands at bit 0; the search is then a plain
  // lowest-set-bit scan.
  assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);
  assign o_any = |i_req;

  always_comb begin
    w_found   = 1'b0;
    w_sum     = 0;
    o_gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = 32'(i_ptr) + k;
        if (w_sum >= NUM_REQ) begin
          w_sum = w_sum - NUM_REQ;
        end
        o_gnt_idx = IDX_W'(w_sum);
      end
    end
    o_gnt = w_found ? (NUM_REQ'(1) << o_gnt_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx byte transmitter.
// Optional feature macro: UART_TX_ARBITER_CRLF_EN (CR LF tail after req_eol grants).
//   clk, rst   - clock, synchronous active-high reset
//   req_valid  - per-requester byte pending
//   req_data   - requester i byte at [8i+7:8i]
//   req_eol    - requester i wants CR LF after its byte (feature only)
//   req_ack    - one-cycle pulse when requester i's byte is captured
//   tx_data    - registered byte to uart_tx
//   tx_send    - registered one-cycle send strobe to uart_tx
//   tx_ready   - uart_tx ready
//   busy       - FSM is outside IDLE
//   grant_idx  - last granted requester
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_eol,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [2:0]           grant_idx
);

  localparam int unsigned     IdxW      = idx_width(NUM_REQ);
  localparam int unsigned     GuardW    = idx_width(GUARD_CYCLES);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_REQ - 1);
  localparam logic [GuardW-1:0] GuardLast = GuardW'(GUARD_CYCLES - 1);

  arb_state_e         r_state, w_state_d;
  logic [IdxW-1:0]    r_ptr, w_ptr_d;
  logic [GuardW-1:0]  r_guard, w_guard_d;
  logic [NUM_REQ-1:0] r_ack, w_ack_d;
  logic [7:0]         r_tx_data, w_tx_data_d;
  logic               r_tx_send, w_tx_send_d;
  logic [2:0]         r_grant_idx, w_grant_idx_d;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IdxW-1:0]    w_gnt_idx;
  logic               w_any;
  logic [7:0]         w_byte;
  logic [IdxW-1:0]    w_ptr_inc;

`ifdef UART_TX_ARBITER_CRLF_EN
  logic  r_eol, w_eol_d;
  tail_e r_tail, w_tail_d;
`else
  logic  w_unused_eol;
  assign w_unused_eol = ^req_eol;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_arbiter (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_byte = w_byte | req_data[8*i +: 8];
      end
    end
  end

  assign w_ptr_inc = (w_gnt_idx == LastIdx) ? '0 : w_gnt_idx + IdxW'(1);

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_guard_d     = r_guard;
    w_ack_d       = '0;
    w_tx_send_d   = 1'b0;
    w_tx_data_d   = r_tx_data;
    w_grant_idx_d = r_grant_idx;
`ifdef UART_TX_ARBITER_CRLF_EN
    w_eol_d       = r_eol;
    w_tail_d      = r_tail;
`endif
    case (r_state)
      StIdle: begin
        if (tx_ready && w_any) begin
          w_tx_send_d   = 1'b1;
          w_tx_data_d   = w_byte;
          w_ack_d       = w_gnt;
          w_grant_idx_d = 3'(w_gnt_idx);
          w_ptr_d       = w_ptr_inc;
          w_guard_d     = '0;
          w_state_d     = StWaitBusy;
`ifdef UART_TX_ARBITER_CRLF_EN
          w_eol_d       = |(req_eol & w_gnt);
          w_tail_d      = PhData;
`endif
        end
      end
      StWaitBusy: begin
        // Guard timeout covers a transmitter whose ready drop was missed.
        if (!tx_ready || (r_guard == GuardLast)) begin
          w_state_d = StWaitDone;
        end else begin
          w_guard_d = r_guard + GuardW'(1);
        end
      end
      StWaitDone: begin
        if (tx_ready) begin
`ifdef UART_TX_ARBITER_CRLF_EN
          if (r_eol && (r_tail == PhData)) begin
            w_state_d = StCr;
          end else if (r_eol && (r_tail == PhCr)) begin
            w_state_d = StLf;
          end else begin
            w_state_d = StIdle;
          end
`else
          w_state_d = StIdle;
`endif
        end
      end
`ifdef UART_TX_ARBITER_CRLF_EN
      StCr: begin
        if (tx_ready) begin
          w_tx_send_d = 1'b1;
          w_tx_data_d = ASCII_CR;
          w_tail_d    = PhCr;
          w_guard_d   = '0;
          w_state_d   = StWaitBusy;
        end
      end
      StLf: begin
        if (tx_ready) begin
          w_tx_send_d = 1'b1;
          w_tx_data_d = ASCII_LF;
          w_tail_d    = PhLf;
          w_guard_d   = '0;
          w_state_d   = StWaitBusy;
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_guard     <= '0;
      r_ack       <= '0;
      r_tx_send   <= 1'b0;
      r_tx_data   <= 8'h00;
      r_grant_idx <= 3'd0;
`ifdef UART_TX_ARBITER_CRLF_EN
      r_eol       <= 1'b0;
      r_tail      <= PhData;
`endif
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_guard     <= w_guard_d;
      r_ack       <= w_ack_d;
      r_tx_send   <= w_tx_send_d;
      r_tx_data   <= w_tx_data_d;
      r_grant_idx <= w_grant_idx_d;
`ifdef UART_TX_ARBITER_CRLF_EN
      r_eol       <= w_eol_d;
      r_tail      <= w_tail_d;
`endif
    end
  end

  assign req_ack   = r_ack;
  assign tx_data   = r_tx_data;
  assign tx_send   = r_tx_send;
  assign grant_idx = r_grant_idx;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a uart_tx ready model plus a scoreboard of
// expected sends (byte, grant index, ack) popped whenever tx_send is seen.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned GC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_eol;
  logic [NR-1:0] req_ack;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_ready;
  logic          busy;
  logic [2:0]    grant_idx;

  // Transmitter model state
  logic m_ready;
  logic hold_low;
  bit   drop_en = 1'b1;
  int   drop_len = 10;
  int   busy_cnt;

  typedef struct packed {
    logic [7:0]    data;
    logic [2:0]    idx;
    logic [NR-1:0] ack;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  assign tx_ready = m_ready & ~hold_low;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_eol   (req_eol),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // uart_tx model: ready drops right after a send strobe and stays low drop_len cycles.
  initial begin
    m_ready  = 1'b1;
    busy_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) m_ready = 1'b1;
      end else if (tx_send && drop_en) begin
        m_ready  = 1'b0;
        busy_cnt = drop_len;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (tx_send) begin
      check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_eq("tx_data", 32'(tx_data), 32'(mon_e.data));
        check_eq("grant_idx", 32'(grant_idx), 32'(mon_e.idx));
        check_eq("req_ack", 32'(req_ack), 32'(mon_e.ack));
      end
    end else if (req_ack != '0) begin
      check_eq("ack_without_send", 32'(req_ack), 0);
    end
  end

  task automatic push(input logic [7:0] d, input logic [2:0] idx, input logic [NR-1:0] ack);
    exp_t x;
    x.data = d;
    x.idx  = idx;
    x.ack  = ack;
    sb.push_back(x);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_send"}, 32'(tx_send), 0);
    check_eq({tag, "_ack"}, 32'(req_ack), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_gidx"}, 32'(grant_idx), 0);
    check_eq({tag, "_data"}, 32'(tx_data), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    req_eol   = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40 && !tx_ready; i++) @(negedge clk);
  endtask

  task automatic wait_send();
    int i;
    i = 0;
    do begin
      @(posedge clk);
      #1;
      i++;
    end while (!tx_send && i < 100);
    check_eq("send_seen", 32'(tx_send), 1);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    check_eq("idle_reached", 32'(busy), 0);
    @(negedge clk);
  endtask

  task automatic grant_one(input logic [NR-1:0] vld, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [2:0] eidx);
    @(negedge clk);
    push((eidx == 3'd1) ? d1 : d0, eidx, (eidx == 3'd1) ? 2'b10 : 2'b01);
    req_data  = {d1, d0};
    req_valid = vld;
    wait_send();
    req_valid = '0;
    wait_idle();
  endtask

  task automatic run_n_sends(input int n, input string tag);
    int sent;
    int i;
    sent = 0;
    i    = 0;
    while (sent < n && i < 400) begin
      @(posedge clk);
      #1;
      i++;
      if (tx_send) sent++;
    end
    req_valid = '0;
    check_eq(tag, 32'(sent), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    logic any_out;
    rst       = 1'b1;
    req_valid = '0;
    req_eol   = '0;
    req_data  = '0;
    hold_low  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: single grant, then repeated grants from requester 0 wrap the pointer
    @(negedge clk);
    push(8'h41, 3'd0, 2'b01);
    req_data  = {8'h00, 8'h41};
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    check_eq("t1_send", 32'(tx_send), 1);
    check_eq("t1_data", 32'(tx_data), 32'h41);
    check_eq("t1_ack", 32'(req_ack), 32'b01);
    check_eq("t1_busy", 32'(busy), 1);
    req_valid = '0;
    wait_idle();
    grant_one(2'b01, 8'h42, 8'h00, 3'd0);
    grant_one(2'b01, 8'h43, 8'h00, 3'd0);

    // 2: both held, strict alternation starting from a freshly reset pointer
    do_reset();
    push(8'h41, 3'd0, 2'b01);
    push(8'h21, 3'd1, 2'b10);
    push(8'h41, 3'd0, 2'b01);
    push(8'h21, 3'd1, 2'b10);
    req_data  = {8'h21, 8'h41};
    req_valid = 2'b11;
    run_n_sends(4, "t2_sends");
    wait_idle();
    check_eq("t2_sb_empty", 32'(sb.size()), 0);

    // 3: no grant while the transmitter is not ready
    do_reset();
    hold_low = 1'b1;
    push(8'h33, 3'd0, 2'b01);
    req_data  = {8'h00, 8'h33};
    req_valid = 2'b01;
    any_out   = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      any_out = any_out | tx_send | (|req_ack);
    end
    check_eq("t3_quiet", 32'(any_out), 0);
    @(negedge clk);
    hold_low = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t3_send_after_ready", 32'(tx_send), 1);
    req_valid = '0;
    wait_idle();

    // 4: ready never drops; guard releases WAIT_BUSY after GC cycles
    do_reset();
    drop_en = 1'b0;
    push(8'h44, 3'd0, 2'b01);
    req_data  = {8'h00, 8'h44};
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    check_eq("t4_send", 32'(tx_send), 1);
    req_valid = '0;
    cnt = 1;
    while (busy && cnt < 50) begin
      @(posedge clk);
      #1;
      if (busy) cnt++;
    end
    check_eq("t4_busy_len", 32'(cnt), 32'(GC + 1));
    drop_en = 1'b1;
    grant_one(2'b10, 8'h00, 8'h55, 3'd1);

    // 5: reset while waiting for the frame to finish
    do_reset();
    push(8'h66, 3'd0, 2'b01);
    req_data  = {8'h00, 8'h66};
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    check_eq("t5_send", 32'(tx_send), 1);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("t5_busy_pre", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    push(8'h77, 3'd1, 2'b10);
    req_data  = {8'h77, 8'h00};
    req_valid = 2'b10;
    @(posedge clk);
    #1;
    check_reset_outputs("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    wait_send();
    req_valid = '0;
    wait_idle();
    grant_one(2'b11, 8'h78, 8'h79, 3'd0);

`ifdef UART_TX_ARBITER_CRLF_EN
    // 6: CR LF tail locks out the competing requester
    do_reset();
    push(8'h5A, 3'd0, 2'b01);
    push(8'h0D, 3'd0, 2'b00);
    push(8'h0A, 3'd0, 2'b00);
    push(8'h12, 3'd1, 2'b10);
    req_eol   = 2'b01;
    req_data  = {8'h12, 8'h5A};
    req_valid = 2'b01;
    wait_send();
    req_valid = 2'b10;
    run_n_sends(3, "t6_sends");
    wait_idle();
    req_eol = '0;
`endif

    check_eq("final_sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx byte transmitter between NUM_REQ independent byte sources, for example the button-selected character and a 1 Hz heartbeat source.
- Uses round-robin arbitration with a valid/ack handshake toward each requester.
- Drives the transmitter's send/data pair and tracks its ready signal, so exactly one byte is in flight at a time.
- Sits between the application logic and uart_tx in the top level.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- GUARD_CYCLES, 4, maximum number of cycles to wait for tx_ready to fall after a send.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  bit i high means requester i has a byte pending.
- req_data  in  8*NUM_REQ  byte for requester i is at bits [8i+7:8i].
- req_eol  in  NUM_REQ  requester i asks for CR LF after its byte; used only with the optional feature.
- req_ack  out  NUM_REQ  one-cycle pulse when requester i's byte is captured.
- tx_data  out  8  byte to uart_tx; registered.
- tx_send  out  1  one-cycle send strobe to uart_tx; registered.
- tx_ready  in  1  ready from uart_tx.
- busy  out  1  high in every state except IDLE.
- grant_idx  out  3  index of the last granted requester.

Behaviour:
- Reset (rst high on a clock edge):
  - State goes to IDLE and the round-robin pointer goes to 0.
  - tx_send, req_ack, busy and grant_idx are all 0; tx_data is 0x00.
  - Reset applies even mid-transfer, and tx_send is never asserted in the cycle following a reset cycle.
- Requester rules:
  - A requester holds valid and its data stable until it sees ack.
  - Dropping valid before ack is legal; that requester is simply not considered at the next arbitration.
- IDLE:
  - Arbitration happens when tx_ready is 1 and req_valid is non-zero.
  - The winner is the first valid index at or after the pointer, searching cyclically upward.
  - Next cycle: tx_send=1, tx_data=winner's byte, req_ack[winner]=1, grant_idx=winner, pointer=(winner+1) mod NUM_REQ, state goes to WAIT_BUSY.
  - If tx_ready is 0 or no requester is valid, remain in IDLE with no outputs pulsed.
- WAIT_BUSY:
  - tx_send and req_ack return to 0.
  - Go to WAIT_DONE when tx_ready is 0.
  - If tx_ready is still 1 after GUARD_CYCLES cycles, go to WAIT_DONE anyway (guard against a missed drop).
- WAIT_DONE:
  - Go to IDLE when tx_ready is 1.
  - With the optional feature and the latched eol flag set, go to CR instead.
- Spacing: a single grant consumes at least one arbitration cycle, one send cycle and one WAIT cycle. Back-to-back requests from the same requester are therefore separated by a full transmitter frame.
- Simultaneous requests: all valid requesters are served strictly in round-robin order. No requester waits longer than NUM_REQ-1 grants.
- Pointer after a single grant: with only requester 0 active, every grant still advances the pointer to 1, and the next search wraps back to 0.

Optional Feature:
- Macro: UART_TX_ARBITER_CRLF_EN.
- Defined:
  - req_eol[winner] is latched at grant time.
  - After the byte completes, states CR and LF each issue one send (0x0D, then 0x0A) using the same send/WAIT_BUSY/WAIT_DONE sequence. No ack is produced for these bytes.
  - Arbitration is locked until LF completes.
  - A reset during CR or LF abandons the sequence.
- Undefined: req_eol is ignored, the CR and LF states do not exist, and WAIT_DONE always returns to IDLE.

Decomposition:
- Package uart_arb_pkg:
  - state encoding: IDLE, WAIT_BUSY, WAIT_DONE, CR, LF;
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A;
  - a function or constant for the grant index width.
- Sub-module rr_arbiter:
  - combinational cyclic priority search;
  - inputs: request vector and pointer;
  - outputs: one-hot grant, grant index, any_req.
- The top-level module holds the FSM, pointer, guard counter and registers.

Test Plan:
1. Reset, then req_valid=01 with byte 0x41 and tx_ready=1 → one cycle later tx_send=1, tx_data=0x41, req_ack=01, busy=1. The model drops ready for 10 cycles → the block returns to IDLE and busy=0 when ready rises.
2. req_valid=11 held, bytes 0x41/0x21, four grants → tx_data sequence 0x41,0x21,0x41,0x21; grant_idx 0,1,0,1; exactly one ack per send.
3. tx_ready=0 during IDLE with valid held for 20 cycles → no tx_send and no ack. tx_ready rises → send issued next cycle.
4. Model never drops ready after a send → the block leaves WAIT_BUSY after exactly 4 cycles and the next grant proceeds normally.
5. rst pulsed while in WAIT_DONE → all outputs 0 and pointer 0 next cycle. With req_valid=10, the next grant goes to requester 1 and then the pointer wraps to 0.
6. With UART_TX_ARBITER_CRLF_EN defined, req_eol=01 with byte 0x5A → sends 0x5A, 0x0D, 0x0A with a single ack. A competing requester 1 is not granted until LF completes.
